qeciphy_tx_frame_scheduler: RTL and testbench
=============================================

// Module: qeciphy_tx_frame_scheduler
// PURPOSE
//  Sequences the TX packet generator. Generates the frame-alignment-word (FAW) and CRC boundary strobes on a fixed 64-slot grid.
//  Owns the one-hot TX link state (off/idle/active): requests from the link controller are latched and applied only on a FAW boundary.
//  Sits between the link-training controller and qeciphy_tx_packet_gen; its outputs drive faw_boundary_i, crc_boundary_i and tx_off/idle/active_i.
// PARAMETERS
//  DATA_PER_CRC  6  data slots preceding each CRC slot
//  CRC_PER_FAW   9  CRC groups per frame; FRAME_LEN = 1 + CRC_PER_FAW*(DATA_PER_CRC+1) = 64
// PORTS
//  clk_i           in   1   TX datapath clock
//  rst_i           in   1   reset, asynchronous, active-high
//  tx_en_i         in   1   level; 1 = run slot grid, 0 = wind down to OFF
//  req_state_i     in   2   requested link state: 00 OFF, 01 IDLE, 10 ACTIVE, 11 reserved
//  faw_boundary_o  out  1   high in slot 0 of each frame
//  crc_boundary_o  out  1   high in CRC slots
//  tx_off_o        out  1   one-hot link state
//  tx_idle_o       out  1   one-hot link state
//  tx_active_o     out  1   one-hot link state
//  slot_o          out  $clog2(FRAME_LEN)  current slot index
//  running_o       out  1   slot grid active
//  req_err_o       out  1   1-cycle pulse: reserved req_state_i sampled
// BEHAVIOUR
//  - One clock domain. Only one clock and one reset. All outputs are registered.
//  - Reset values:
//      - faw_boundary_o = crc_boundary_o = running_o = req_err_o = 0
//      - tx_off_o = 1, tx_idle_o = tx_active_o = 0
//      - slot_o = 0, pending state = OFF, FSM = STOPPED
//  - FSM states:
//      - STOPPED: grid halted.
//          - When tx_en_i = 1, go to RUNNING.
//          - The first RUNNING cycle is slot 0, with faw_boundary_o = 1.
//      - RUNNING: slot increments every cycle and wraps FRAME_LEN-1 -> 0.
//          - When tx_en_i = 0 is sampled, go to DRAINING and force pending = OFF.
//      - DRAINING: the grid keeps running to the end of the current frame.
//          - At the wrap, emit one terminal slot-0 cycle: faw_boundary_o = 1, state = OFF.
//          - Then go to STOPPED with slot_o = 0.
//          - If tx_en_i returns to 1 during DRAINING, drain still completes, then restart from STOPPED.
//  - Slot map (defaults):
//      - slot 0 = FAW.
//      - slot s > 0 with s % (DATA_PER_CRC+1) == 0 = CRC, i.e. slots 7, 14, ..., 63.
//      - All other slots are data.
//  - FAW and CRC are never high together. No CRC strobe occurs before the first FAW after reset.
//  - State handling:
//      - req_state_i is sampled every cycle while not STOPPED; a legal value overwrites pending.
//      - The value 11 leaves pending unchanged and pulses req_err_o on the next cycle.
//      - The one-hot state outputs change only in the same cycle that faw_boundary_o = 1, taking the pending value latched by the previous cycle.
//      - Between FAWs the state outputs are stable. They are exactly one-hot at all times.
//      - A request arriving in the slot-0 cycle itself applies at the next frame.
//  - Last-request-wins: multiple requests in one frame collapse to the final legal one.
//  - Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous), with no terminal FAW.
// CONFIGURATION
//  QECIPHY_TX_SCHED_STATS_EN
//    defined:
//      - Adds output frame_cnt_o [31:0]: count of FAW strobes, saturating at 32'hFFFF_FFFF, reset 0.
//      - Adds output state_chg_o: 1-cycle pulse in any FAW cycle where the state outputs changed.
//    undefined: ports absent, no counter logic.
// STRUCTURE
//  - qeciphy_pkg:
//      - tx_state_e {TX_OFF = 2'b00, TX_IDLE = 2'b01, TX_ACTIVE = 2'b10}
//      - sched_fsm_e {STOPPED, RUNNING, DRAINING}
//      - QECIPHY_DATA_PER_CRC = 6, QECIPHY_CRC_PER_FAW = 9
//  - Sub-module qeciphy_tx_slot_counter:
//      - Modulo-FRAME_LEN counter with enable.
//      - Decodes is_faw and is_crc (combinationally, next-slot lookahead registered).
//  - Top level holds the FSM, pending-state register, one-hot encoding and optional stats.
// TESTING
//  T1 reset, tx_en_i=1 from cycle 3 -> first FAW at cycle 4; CRC at +7,+14..+63; next FAW at +64; tx_off_o=1 throughout (req OFF)
//  T2 req ACTIVE at slot 20 -> tx_active_o=1 exactly at next slot-0 cycle; no change in slots 21..63
//  T3 req IDLE at slot 10 then ACTIVE at slot 50 -> only ACTIVE applied at next FAW; IDLE never visible
//  T4 running ACTIVE, tx_en_i=0 at slot 30 -> strobes continue to slot 63, terminal FAW with tx_off_o=1, then running_o=0, no further strobes
//  T5 req_state_i=11 at slot 5 -> req_err_o pulse next cycle; state at next FAW is the prior pending value
//  T6 rst_i pulse at slot 40 -> all outputs at reset values the same cycle; restart gives clean FAW-first sequence; (STATS_EN) frame_cnt_o=0

Source files
------------

// File: rtl/qeciphy_pkg.sv
// Shared types and constants for the QECi PHY TX path.
// Holds the link-state and scheduler FSM encodings plus the default slot-grid geometry.
package qeciphy_pkg;

  typedef enum logic [1:0] {
    TX_OFF    = 2'b00,
    TX_IDLE   = 2'b01,
    TX_ACTIVE = 2'b10
  } tx_state_e;

  typedef enum logic [1:0] {
    STOPPED,
    RUNNING,
    DRAINING
  } sched_fsm_e;

  localparam int QECIPHY_DATA_PER_CRC = 6;
  localparam int QECIPHY_CRC_PER_FAW  = 9;

  // One-hot vector ordered {active, idle, off}; anything unexpected maps to OFF.
  function automatic logic [2:0] tx_state_onehot(input tx_state_e s);
    case (s)
      TX_IDLE:   return 3'b010;
      TX_ACTIVE: return 3'b100;
      default:   return 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/qeciphy_tx_slot_counter.sv
// Modulo-FRAME_LEN slot counter with registered FAW/CRC strobes.
// Strobes are decoded from the next slot so they line up with the registered slot index.
module qeciphy_tx_slot_counter
  import qeciphy_pkg::*;
#(
  parameter int  DATA_PER_CRC = QECIPHY_DATA_PER_CRC,
  parameter int  CRC_PER_FAW  = QECIPHY_CRC_PER_FAW,
  localparam int FRAME_LEN    = 1 + CRC_PER_FAW * (DATA_PER_CRC + 1),
  localparam int SLOT_W       = $clog2(FRAME_LEN)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              adv_i,
  output logic [SLOT_W-1:0] slot_o,
  output logic              last_o,
  output logic              faw_nxt_o,
  output logic              faw_o,
  output logic              crc_o
);

  logic [SLOT_W-1:0] slot_nxt;
  logic              strobe_en;
  logic              crc_nxt;

  assign last_o    = (slot_o == SLOT_W'(FRAME_LEN - 1));
  assign strobe_en = start_i | adv_i;

  always_comb begin
    slot_nxt = slot_o;
    if (start_i) begin
      slot_nxt = '0;
    end else if (adv_i) begin
      slot_nxt = last_o ? '0 : slot_o + 1'b1;
    end
  end

  assign faw_nxt_o = strobe_en && (slot_nxt == '0);
  assign crc_nxt   = strobe_en && (slot_nxt != '0) && ((int'(slot_nxt) % (DATA_PER_CRC + 1)) == 0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_o <= '0;
      faw_o  <= 1'b0;
      crc_o  <= 1'b0;
    end else begin
      slot_o <= slot_nxt;
      faw_o  <= faw_nxt_o;
      crc_o  <= crc_nxt;
    end
  end

endmodule

// File: rtl/qeciphy_tx_frame_scheduler.sv
// TX frame scheduler: FAW/CRC slot grid plus one-hot link state applied on FAW boundaries.
// Optional QECIPHY_TX_SCHED_STATS_EN adds frame_cnt_o and state_chg_o.
module qeciphy_tx_frame_scheduler
  import qeciphy_pkg::*;
#(
  parameter int  DATA_PER_CRC = QECIPHY_DATA_PER_CRC,
  parameter int  CRC_PER_FAW  = QECIPHY_CRC_PER_FAW,
  localparam int FRAME_LEN    = 1 + CRC_PER_FAW * (DATA_PER_CRC + 1),
  localparam int SLOT_W       = $clog2(FRAME_LEN)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tx_en_i,
  input  logic [1:0]        req_state_i,
  output logic              faw_boundary_o,
  output logic              crc_boundary_o,
  output logic              tx_off_o,
  output logic              tx_idle_o,
  output logic              tx_active_o,
  output logic [SLOT_W-1:0] slot_o,
  output logic              running_o,
  output logic              req_err_o
`ifdef QECIPHY_TX_SCHED_STATS_EN
  ,
  output logic [31:0]       frame_cnt_o,
  output logic              state_chg_o
`endif
);

  sched_fsm_e fsm, fsm_nxt;
  tx_state_e  pending, pend_nxt;
  logic [2:0] state_oh, oh_nxt;
  logic       term, term_nxt;
  logic       running_nxt, err_nxt;
  logic       start, adv, last, faw_nxt;

  qeciphy_tx_slot_counter #(
    .DATA_PER_CRC (DATA_PER_CRC),
    .CRC_PER_FAW  (CRC_PER_FAW)
  ) u_slot_counter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start),
    .adv_i     (adv),
    .slot_o    (slot_o),
    .last_o    (last),
    .faw_nxt_o (faw_nxt),
    .faw_o     (faw_boundary_o),
    .crc_o     (crc_boundary_o)
  );

  always_comb begin
    fsm_nxt     = fsm;
    pend_nxt    = pending;
    term_nxt    = term;
    running_nxt = running_o;
    err_nxt     = 1'b0;
    start       = 1'b0;
    adv         = 1'b0;

    if (fsm != STOPPED) begin
      if (req_state_i == 2'b11) begin
        err_nxt = 1'b1;
      end else begin
        pend_nxt = tx_state_e'(req_state_i);
      end
    end

    case (fsm)
      STOPPED: begin
        if (tx_en_i) begin
          fsm_nxt     = RUNNING;
          start       = 1'b1;
          running_nxt = 1'b1;
        end
      end
      RUNNING: begin
        adv = 1'b1;
        if (!tx_en_i) begin
          fsm_nxt  = DRAINING;
          pend_nxt = TX_OFF;
        end
      end
      DRAINING: begin
        // Requests are ignored while winding down; the terminal FAW always lands on OFF.
        pend_nxt = TX_OFF;
        if (term) begin
          fsm_nxt     = STOPPED;
          term_nxt    = 1'b0;
          running_nxt = 1'b0;
        end else begin
          adv = 1'b1;
          if (last) term_nxt = 1'b1;
        end
      end
      default: begin
        fsm_nxt     = STOPPED;
        running_nxt = 1'b0;
      end
    endcase

    // The registered pending value is applied, so a request seen in slot 0 waits a frame.
    oh_nxt = faw_nxt ? tx_state_onehot(pending) : state_oh;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm       <= STOPPED;
      pending   <= TX_OFF;
      state_oh  <= 3'b001;
      term      <= 1'b0;
      running_o <= 1'b0;
      req_err_o <= 1'b0;
    end else begin
      fsm       <= fsm_nxt;
      pending   <= pend_nxt;
      state_oh  <= oh_nxt;
      term      <= term_nxt;
      running_o <= running_nxt;
      req_err_o <= err_nxt;
    end
  end

  assign tx_off_o    = state_oh[0];
  assign tx_idle_o   = state_oh[1];
  assign tx_active_o = state_oh[2];

`ifdef QECIPHY_TX_SCHED_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_o <= '0;
      state_chg_o <= 1'b0;
    end else begin
      if (faw_nxt && (frame_cnt_o != '1)) frame_cnt_o <= frame_cnt_o + 32'd1;
      state_chg_o <= faw_nxt && (oh_nxt != state_oh);
    end
  end
`endif

endmodule

// File: tb/tb_qeciphy_tx_frame_scheduler.sv
// Directed self-checking bench for qeciphy_tx_frame_scheduler (64-slot grid, FAW/CRC, link state).
module tb_qeciphy_tx_frame_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_en = 1'b0;
  logic [1:0] req = 2'b00;
  logic       faw, crc, off, idle, act, running, err;
  logic [5:0] slot;
`ifdef QECIPHY_TX_SCHED_STATS_EN
  logic [31:0] frame_cnt;
  logic        state_chg;
`endif

  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_slot = 0;
  logic [2:0] exp_oh = 3'b001;
  logic [2:0] exp_next_oh = 3'b001;
  logic       exp_err = 1'b0;

  always #5 clk = ~clk;

  qeciphy_tx_frame_scheduler dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tx_en_i        (tx_en),
    .req_state_i    (req),
    .faw_boundary_o (faw),
    .crc_boundary_o (crc),
    .tx_off_o       (off),
    .tx_idle_o      (idle),
    .tx_active_o    (act),
    .slot_o         (slot),
    .running_o      (running),
    .req_err_o      (err)
`ifdef QECIPHY_TX_SCHED_STATS_EN
    ,
    .frame_cnt_o    (frame_cnt),
    .state_chg_o    (state_chg)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grid(input string tag);
    check({tag, " slot"}, 32'(slot), 32'(exp_slot));
    check({tag, " faw"}, 32'(faw), 32'(exp_slot == 0));
    check({tag, " crc"}, 32'(crc), 32'((exp_slot != 0) && (exp_slot % 7 == 0)));
    check({tag, " onehot"}, 32'({act, idle, off}), 32'(exp_oh));
    check({tag, " running"}, 32'(running), 32'd1);
    check({tag, " req_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic chk_reset(input string tag);
    check({tag, " faw"}, 32'(faw), 32'd0);
    check({tag, " crc"}, 32'(crc), 32'd0);
    check({tag, " onehot"}, 32'({act, idle, off}), 32'd1);
    check({tag, " slot"}, 32'(slot), 32'd0);
    check({tag, " running"}, 32'(running), 32'd0);
    check({tag, " req_err"}, 32'(err), 32'd0);
`ifdef QECIPHY_TX_SCHED_STATS_EN
    check({tag, " frame_cnt"}, frame_cnt, 32'd0);
`endif
  endtask

  task automatic chk_stopped(input string tag);
    check({tag, " faw"}, 32'(faw), 32'd0);
    check({tag, " crc"}, 32'(crc), 32'd0);
    check({tag, " slot"}, 32'(slot), 32'd0);
    check({tag, " running"}, 32'(running), 32'd0);
    check({tag, " onehot"}, 32'({act, idle, off}), 32'd1);
  endtask

  // One grid cycle: the slot advances, the state takes the hand-set value at slot 0.
  task automatic adv(input string tag);
    logic prev_bad;
    prev_bad = (req == 2'b11);
    tick();
    exp_slot = (exp_slot + 1) % 64;
    if (exp_slot == 0) exp_oh = exp_next_oh;
    exp_err = prev_bad;
    chk_grid(tag);
  endtask

  task automatic adv_to(input int target, input string tag);
    do adv(tag); while (exp_slot != target);
  endtask

  task automatic expect_start(input string tag, input logic [2:0] oh);
    exp_slot = 0;
    exp_oh   = oh;
    exp_err  = 1'b0;
    chk_grid(tag);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk_reset("reset");
    tick();
    rst = 1'b0;
    tick();
    tick();
    tx_en = 1'b1;
    check("t1 pre faw", 32'(faw), 32'd0);

    // T1: first FAW one cycle after tx_en, full frame of CRC strobes, state OFF.
    tick();
    expect_start("t1 start", 3'b001);
    adv_to(0, "t1");
`ifdef QECIPHY_TX_SCHED_STATS_EN
    check("t1 frame_cnt", frame_cnt, 32'd2);
`endif

    // T2: ACTIVE requested at slot 20 appears only at the next slot 0.
    adv_to(20, "t2");
    req = 2'b10;
    exp_next_oh = 3'b100;
    adv_to(0, "t2");

    // T3: IDLE then ACTIVE in one frame; only the last one lands.
    adv_to(10, "t3");
    req = 2'b01;
    adv_to(50, "t3");
    req = 2'b10;
    adv_to(0, "t3");

    // T5: IDLE latched, then reserved code held; pending stays IDLE.
    adv_to(2, "t5");
    req = 2'b01;
    exp_next_oh = 3'b010;
    adv_to(5, "t5");
    req = 2'b11;
    adv_to(0, "t5");
    // Request during the slot-0 cycle itself waits for the following frame.
    req = 2'b10;
    exp_next_oh = 3'b100;
    adv_to(0, "t5 slot0 req");

    // T4: tx_en drops at slot 30, drain to a terminal OFF FAW, then silence.
    adv_to(30, "t4");
    tx_en = 1'b0;
    exp_next_oh = 3'b001;
    adv_to(0, "t4 drain");
`ifdef QECIPHY_TX_SCHED_STATS_EN
    check("t4 frame_cnt", frame_cnt, 32'd7);
`endif
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_stopped("t4 stopped");
    end

    // T6: restart, then asynchronous reset mid-frame.
    tx_en = 1'b1;
    tick();
    expect_start("t6 restart", 3'b001);
    adv_to(40, "t6 pre");
    rst = 1'b1;
    #1 chk_reset("t6 async");
    tick();
    chk_reset("t6 held");
    rst = 1'b0;
    tick();
    expect_start("t6 restart", 3'b001);
`ifdef QECIPHY_TX_SCHED_STATS_EN
    check("t6 frame_cnt", frame_cnt, 32'd1);
`endif
    exp_next_oh = 3'b100;
    adv_to(0, "t6 frame");

    // tx_en returns mid-drain: drain still completes, one stopped cycle, then restart.
    adv_to(30, "redrain");
    tx_en = 1'b0;
    exp_next_oh = 3'b001;
    adv_to(50, "redrain");
    tx_en = 1'b1;
    adv_to(0, "redrain");
    tick();
    chk_stopped("redrain gap");
    tick();
    expect_start("redrain restart", 3'b001);
    adv_to(8, "redrain run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish (got running, required finish)");
    $fatal(1);
  end

endmodule
